// File: rtl/rf_debug_access_ctrl_pkg.sv
// Shared types and constants for the register-file debug access controller.
package rf_dbg_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    localparam logic [RF_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STALL = 2'd2,
        RESP  = 2'd3
    } dbg_state_e;

    // Command latched at accept and held until the response handshake.
    typedef struct packed {
        logic             we;
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] wdata;
    } dbg_cmd_t;

    function automatic logic is_zero_write(input logic we, input logic [RF_AW-1:0] addr);
        return we && (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/rf_debug_access_ctrl_if.sv
// Host/debug command and response channel (valid/ready both ways).
interface rf_dbg_if;
    import rf_dbg_pkg::*;

    logic             dbg_req_valid;
    logic             dbg_req_ready;
    logic             dbg_req_we;
    logic [RF_AW-1:0] dbg_req_addr;
    logic [RF_DW-1:0] dbg_req_wdata;
    logic             dbg_rsp_valid;
    logic             dbg_rsp_ready;
    logic [RF_DW-1:0] dbg_rsp_rdata;
    logic             dbg_rsp_err;

    modport master (
        output dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata, dbg_rsp_ready,
        input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata, dbg_rsp_err
    );

    modport slave (
        input  dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata, dbg_rsp_ready,
        output dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata, dbg_rsp_err
    );

endinterface

// File: rtl/rf_debug_access_ctrl_starve_cnt.sv
// Saturating wait counter; tc_o flags the last tolerated starved cycle.
module rf_dbg_starve_cnt #(
    parameter int STARVE_LIMIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(STARVE_LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)                        cnt_d = '0;
        else if (en_i && cnt_q != TC_VAL) cnt_d = cnt_q + CNT_W'(1);
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/rf_debug_access_ctrl.sv
// Borrows the RF write port / read port 2 in idle pipeline slots for debug
// accesses, escalating to a pipeline stall when starved too long.
module rf_debug_access_ctrl
    import rf_dbg_pkg::*;
#(
    parameter int STARVE_LIMIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_regwrite,
    input  logic [RF_AW-1:0] wb_writeaddr,
    input  logic [RF_DW-1:0] wb_writedata,
    input  logic             id_regread2,
    input  logic [RF_AW-1:0] id_readaddr2,
    output logic             rf_regwrite,
    output logic [RF_AW-1:0] rf_writeaddr,
    output logic [RF_DW-1:0] rf_writedata,
    output logic             rf_regread2,
    output logic [RF_AW-1:0] rf_readaddr2,
    input  logic [RF_DW-1:0] rf_readdata2,
    rf_dbg_if.slave          dbg,
    output logic             stall_req
);

    dbg_state_e       state_q, state_d;
    dbg_cmd_t         cmd_q, cmd_d;
    logic [RF_DW-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic accept, wr_zero, slot_free, in_issue_st, issue, cnt_en, starve_tc;

    // Ready depends on state only, so accept is just valid while IDLE.
    assign accept      = (state_q == IDLE) && dbg.dbg_req_valid;
    assign wr_zero     = is_zero_write(dbg.dbg_req_we, dbg.dbg_req_addr);
    assign slot_free   = cmd_q.we ? !wb_regwrite : !id_regread2;
    assign in_issue_st = (state_q == WAIT) || (state_q == STALL);
    assign issue       = in_issue_st && slot_free;
    assign cnt_en      = (state_q == WAIT) && !slot_free;

    rf_dbg_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (cnt_en),
        .tc_o  (starve_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = wr_zero ? RESP : WAIT;
            WAIT: begin
                if (slot_free)      state_d = RESP;
                else if (starve_tc) state_d = STALL;
            end
            STALL:   if (slot_free) state_d = RESP;
            RESP:    if (dbg.dbg_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Response payload only moves at accept or issue, so it is stable in RESP.
    always_comb begin
        cmd_d   = cmd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            cmd_d.we    = dbg.dbg_req_we;
            cmd_d.addr  = dbg.dbg_req_addr;
            cmd_d.wdata = dbg.dbg_req_wdata;
            rdata_d     = '0;
            err_d       = wr_zero;
        end else if (issue && !cmd_q.we) begin
            rdata_d = (cmd_q.addr == REG_ZERO) ? '0 : rf_readdata2;
        end
    end

    always_comb begin
        rf_regwrite       = wb_regwrite;
        rf_writeaddr      = wb_writeaddr;
        rf_writedata      = wb_writedata;
        rf_regread2       = id_regread2;
        rf_readaddr2      = id_readaddr2;
        dbg.dbg_req_ready = (state_q == IDLE);
        dbg.dbg_rsp_valid = (state_q == RESP);
        dbg.dbg_rsp_rdata = rdata_q;
        dbg.dbg_rsp_err   = err_q;
        stall_req         = (state_q == STALL);
        if (issue) begin
            if (cmd_q.we) begin
                rf_regwrite  = 1'b1;
                rf_writeaddr = cmd_q.addr;
                rf_writedata = cmd_q.wdata;
            end else begin
                rf_regread2  = 1'b1;
                rf_readaddr2 = cmd_q.addr;
            end
        end
        // Nothing leaves the block while reset is held, not even pass-through.
        if (rst) begin
            rf_regwrite       = 1'b0;
            rf_writeaddr      = '0;
            rf_writedata      = '0;
            rf_regread2       = 1'b0;
            rf_readaddr2      = '0;
            dbg.dbg_req_ready = 1'b0;
            dbg.dbg_rsp_valid = 1'b0;
            dbg.dbg_rsp_rdata = '0;
            dbg.dbg_rsp_err   = 1'b0;
            stall_req         = 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_debug_access_ctrl.sv
// Randomized self-checking bench: register-file model plus a shadow reference array.
module tb_rf_debug_access_ctrl;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_init;
    logic        wb_regwrite;
    logic [4:0]  wb_writeaddr;
    logic [31:0] wb_writedata;
    logic        id_regread2;
    logic [4:0]  id_readaddr2;
    logic        rf_regwrite;
    logic [4:0]  rf_writeaddr;
    logic [31:0] rf_writedata;
    logic        rf_regread2;
    logic [4:0]  rf_readaddr2;
    logic [31:0] rf_readdata2;
    logic        stall_req;

    logic [31:0] rf_mem [32];
    logic [31:0] ref_rf [32];
    int checks = 0;
    int errors = 0;

    rf_dbg_if dif();

    rf_debug_access_ctrl #(.STARVE_LIMIT(LIM), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_regwrite  (wb_regwrite),
        .wb_writeaddr (wb_writeaddr),
        .wb_writedata (wb_writedata),
        .id_regread2  (id_regread2),
        .id_readaddr2 (id_readaddr2),
        .rf_regwrite  (rf_regwrite),
        .rf_writeaddr (rf_writeaddr),
        .rf_writedata (rf_writedata),
        .rf_regread2  (rf_regread2),
        .rf_readaddr2 (rf_readaddr2),
        .rf_readdata2 (rf_readdata2),
        .dbg          (dif.slave),
        .stall_req    (stall_req)
    );

    always #5 clk = ~clk;

    // Register file environment: r0 hardwired, combinational read port 2.
    always @(posedge clk) begin
        if (mem_init) for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
        else if (rf_regwrite && rf_writeaddr != 5'd0) rf_mem[rf_writeaddr] <= rf_writedata;
    end
    assign rf_readdata2 = (rf_readaddr2 == 5'd0) ? 32'd0 : rf_mem[rf_readaddr2];

    // Drives one command; busy = cycles after accept that the needed port is taken.
    task automatic run_cmd(
        input  logic we, input logic [4:0] addr, input logic [31:0] wd,
        input  int busy, input int hold,
        output int t_iss, output int t_rsp, output int t_hs,
        output int n_wr, output int n_rd, output int st_first, output int n_st,
        output int pt_err, output int unstable, output int rdy_rsp, output int rdy_acc,
        output logic [4:0] wr_a, output logic [31:0] wr_d,
        output logic [31:0] rdata, output logic err, output logic [31:0] snap);
        logic busy_now;
        t_iss = -1; t_rsp = -1; t_hs = -1; n_wr = 0; n_rd = 0; st_first = -1; n_st = 0;
        pt_err = 0; unstable = 0; rdy_rsp = 0; rdy_acc = 0;
        wr_a = 5'd0; wr_d = 32'd0; rdata = 32'd0; err = 1'b0; snap = 32'd0;
        for (int k = 0; k < 200 && t_hs < 0; k++) begin
            @(posedge clk); #1;
            dif.dbg_req_valid = (k == 0);
            dif.dbg_req_we    = (k == 0) ? we : 1'($urandom);
            dif.dbg_req_addr  = (k == 0) ? addr : 5'($urandom);
            dif.dbg_req_wdata = (k == 0) ? wd : $urandom;
            dif.dbg_rsp_ready = (t_rsp >= 0) && (k >= t_rsp + hold);
            busy_now = (k >= 1) && (k <= busy);
            if (we) begin
                wb_regwrite  = busy_now;
                wb_writeaddr = 5'($urandom);
                wb_writedata = $urandom;
                id_regread2  = 1'($urandom);
                id_readaddr2 = 5'($urandom);
            end else begin
                id_regread2  = busy_now;
                id_readaddr2 = 5'($urandom);
                wb_regwrite  = 1'($urandom);
                wb_writeaddr = 5'($urandom);
                if (wb_writeaddr == addr) wb_writeaddr = addr ^ 5'd1;
                wb_writedata = $urandom;
            end
            @(negedge clk);
            if (k == 0) rdy_acc = int'(dif.dbg_req_ready);
            if (k == busy + 1) snap = (addr == 5'd0) ? 32'd0 : ref_rf[addr];
            if (wb_regwrite && (rf_regwrite !== 1'b1 || rf_writeaddr !== wb_writeaddr ||
                                rf_writedata !== wb_writedata)) pt_err++;
            if (id_regread2 && (rf_regread2 !== 1'b1 || rf_readaddr2 !== id_readaddr2)) pt_err++;
            if (!wb_regwrite && rf_regwrite === 1'b1) begin
                n_wr++; t_iss = k; wr_a = rf_writeaddr; wr_d = rf_writedata;
            end
            if (!id_regread2 && rf_regread2 === 1'b1) begin
                n_rd++; t_iss = k;
            end
            if (stall_req === 1'b1) begin
                n_st++;
                if (st_first < 0) st_first = k;
            end
            if (dif.dbg_rsp_valid === 1'b1) begin
                if (t_rsp < 0) begin
                    t_rsp = k; rdata = dif.dbg_rsp_rdata; err = dif.dbg_rsp_err;
                end else if (dif.dbg_rsp_rdata !== rdata || dif.dbg_rsp_err !== err) begin
                    unstable++;
                end
                if (dif.dbg_req_ready !== 1'b0) rdy_rsp++;
                if (dif.dbg_rsp_ready) t_hs = k;
            end
            if (wb_regwrite && wb_writeaddr != 5'd0) ref_rf[wb_writeaddr] = wb_writedata;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_init = 1'b1;
        wb_regwrite = 1'b1; wb_writeaddr = 5'd3; wb_writedata = 32'h1111_2222;
        id_regread2 = 1'b1; id_readaddr2 = 5'd4;
        dif.dbg_req_valid = 1'b1; dif.dbg_req_we = 1'b1; dif.dbg_req_addr = 5'd4;
        dif.dbg_req_wdata = 32'h5; dif.dbg_rsp_ready = 1'b0;
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dif.dbg_req_ready, dif.dbg_rsp_valid, dif.dbg_rsp_err, stall_req, rf_regwrite, rf_regread2} !== 6'd0 ||
            dif.dbg_rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b rsp_valid=%b err=%b stall=%b rf_we=%b rf_re=%b rdata=%h, all required 0",
                     dif.dbg_req_ready, dif.dbg_rsp_valid, dif.dbg_rsp_err, stall_req, rf_regwrite, rf_regread2, dif.dbg_rsp_rdata);
        end
        mem_init = 1'b0; rst = 1'b0; dif.dbg_req_valid = 1'b0;
        wb_regwrite = 1'b0; wb_writeaddr = 5'd17; wb_writedata = 32'hCAFE_0017;
        id_regread2 = 1'b1; id_readaddr2 = 5'd12;
        @(posedge clk); @(negedge clk);
        checks++;
        if (dif.dbg_req_ready !== 1'b1 || dif.dbg_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got ready=%b rsp_valid=%b required 1/0", dif.dbg_req_ready, dif.dbg_rsp_valid);
        end
        checks++;
        if (rf_regwrite !== 1'b0 || rf_writeaddr !== 5'd17 || rf_writedata !== 32'hCAFE_0017 ||
            rf_regread2 !== 1'b1 || rf_readaddr2 !== 5'd12) begin
            errors++;
            $display("FAIL passthrough got we=%b wa=%0d wd=%h re=%b ra=%0d required 0/17/cafe0017/1/12",
                     rf_regwrite, rf_writeaddr, rf_writedata, rf_regread2, rf_readaddr2);
        end
    endtask

    task automatic test_basic();
        int ti, tr, th, nw, nr, sf, ns, pe, us, rr, ra;
        logic [4:0] wa; logic [31:0] wdat, rd, sn; logic er;
        run_cmd(1'b1, 5'd5, 32'hDEAD_BEEF, 0, 1, ti, tr, th, nw, nr, sf, ns, pe, us, rr, ra, wa, wdat, rd, er, sn);
        ref_rf[5] = 32'hDEAD_BEEF;
        checks++;
        if (nw !== 1 || wa !== 5'd5 || wdat !== 32'hDEAD_BEEF || ti !== 1) begin
            errors++;
            $display("FAIL basic_wr_pulse got n=%0d addr=%0d data=%h t=%0d required 1/5/deadbeef/1", nw, wa, wdat, ti);
        end
        checks++;
        if (ra !== 1 || tr !== 2 || er !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL basic_wr_rsp got acc=%0d t_rsp=%0d err=%b rdata=%h required 1/2/0/0", ra, tr, er, rd);
        end
        run_cmd(1'b0, 5'd5, 32'd0, 0, 1, ti, tr, th, nw, nr, sf, ns, pe, us, rr, ra, wa, wdat, rd, er, sn);
        checks++;
        if (nr !== 1 || tr !== 2 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL basic_rd got n=%0d t_rsp=%0d rdata=%h err=%b required 1/2/deadbeef/0", nr, tr, rd, er);
        end
    endtask

    task automatic test_reg0();
        int ti, tr, th, nw, nr, sf, ns, pe, us, rr, ra;
        logic [4:0] wa; logic [31:0] wdat, rd, sn; logic er;
        run_cmd(1'b1, 5'd0, 32'h1234, 0, 1, ti, tr, th, nw, nr, sf, ns, pe, us, rr, ra, wa, wdat, rd, er, sn);
        checks++;
        if (nw !== 0 || tr !== 1 || er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL reg0_write got pulses=%0d t_rsp=%0d err=%b rdata=%h required 0/1/1/0", nw, tr, er, rd);
        end
        run_cmd(1'b0, 5'd0, 32'd0, 0, 1, ti, tr, th, nw, nr, sf, ns, pe, us, rr, ra, wa, wdat, rd, er, sn);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0 || tr !== 2) begin
            errors++;
            $display("FAIL reg0_read got rdata=%h err=%b t_rsp=%0d required 0/0/2", rd, er, tr);
        end
    endtask

    task automatic test_wb_busy();
        int ti, tr, th, nw, nr, sf, ns, pe, us, rr, ra;
        logic [4:0] wa; logic [31:0] wdat, rd, sn; logic er;
        logic [31:0] v = $urandom;
        run_cmd(1'b1, 5'd12, v, 3, 1, ti, tr, th, nw, nr, sf, ns, pe, us, rr, ra, wa, wdat, rd, er, sn);
        ref_rf[12] = v;
        checks++;
        if (ti !== 4 || nw !== 1 || wa !== 5'd12 || wdat !== v || tr !== 5) begin
            errors++;
            $display("FAIL wb_busy_issue got t=%0d n=%0d addr=%0d data=%h t_rsp=%0d required 4/1/12/%h/5", ti, nw, wa, wdat, tr, v);
        end
        checks++;
        if (ns !== 0 || pe !== 0) begin
            errors++;
            $display("FAIL wb_busy_nostall got stall_cycles=%0d passthru_errs=%0d required 0/0", ns, pe);
        end
    endtask

    task automatic test_starve();
        int ti, tr, th, nw, nr, sf, ns, pe, us, rr, ra;
        logic [4:0] wa; logic [31:0] wdat, rd, sn; logic er;
        logic [31:0] v = $urandom;
        run_cmd(1'b1, 5'd7, v, 0, 1, ti, tr, th, nw, nr, sf, ns, pe, us, rr, ra, wa, wdat, rd, er, sn);
        ref_rf[7] = v;
        run_cmd(1'b0, 5'd7, 32'd0, 10, 1, ti, tr, th, nw, nr, sf, ns, pe, us, rr, ra, wa, wdat, rd, er, sn);
        checks++;
        if (sf !== LIM + 1 || ns !== 10 - LIM + 1) begin
            errors++;
            $display("FAIL starve_stall got first=%0d cycles=%0d required %0d/%0d", sf, ns, LIM + 1, 10 - LIM + 1);
        end
        checks++;
        if (ti !== 11 || tr !== 12 || rd !== v || er !== 1'b0) begin
            errors++;
            $display("FAIL starve_read got t_iss=%0d t_rsp=%0d rdata=%h err=%b required 11/12/%h/0", ti, tr, rd, er, v);
        end
    endtask

    task automatic test_rsp_hold();
        int ti, tr, th, nw, nr, sf, ns, pe, us, rr, ra;
        logic [4:0] wa; logic [31:0] wdat, rd, sn; logic er;
        run_cmd(1'b0, 5'd12, 32'd0, 0, 5, ti, tr, th, nw, nr, sf, ns, pe, us, rr, ra, wa, wdat, rd, er, sn);
        checks++;
        if (us !== 0 || rr !== 0 || th !== tr + 5 || rd !== ref_rf[12]) begin
            errors++;
            $display("FAIL rsp_hold got unstable=%0d ready_in_resp=%0d hs=%0d rsp=%0d rdata=%h required 0/0/rsp+5/%h",
                     us, rr, th, tr, rd, ref_rf[12]);
        end
    endtask

    task automatic test_reset_stall();
        int bad = 0;
        logic [31:0] old9 = ref_rf[9];
        @(posedge clk); #1;
        dif.dbg_req_valid = 1'b1; dif.dbg_req_we = 1'b1; dif.dbg_req_addr = 5'd9;
        dif.dbg_req_wdata = 32'hA5A5_0009; dif.dbg_rsp_ready = 1'b0;
        wb_regwrite = 1'b0; id_regread2 = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= LIM + 2; k++) begin
            @(posedge clk); #1;
            dif.dbg_req_valid = 1'b0;
            wb_regwrite = 1'b1; wb_writeaddr = 5'd0; wb_writedata = $urandom;
            @(negedge clk);
            if (rf_regwrite === 1'b1 && rf_writeaddr === 5'd9) bad++;
        end
        checks++;
        if (stall_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_stall_pre got stall=%b required 1", stall_req);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (stall_req !== 1'b0 || dif.dbg_rsp_valid !== 1'b0 || dif.dbg_req_ready !== 1'b0 || rf_regwrite !== 1'b0) begin
            errors++;
            $display("FAIL rst_async got stall=%b rsp_valid=%b ready=%b rf_we=%b required 0/0/0/0",
                     stall_req, dif.dbg_rsp_valid, dif.dbg_req_ready, rf_regwrite);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; wb_regwrite = 1'b0;
        @(negedge clk);
        checks++;
        if (dif.dbg_req_ready !== 1'b1 || stall_req !== 1'b0 || dif.dbg_rsp_valid !== 1'b0 || bad !== 0 || rf_mem[9] !== old9) begin
            errors++;
            $display("FAIL rst_release got ready=%b stall=%b rsp_valid=%b dbg_writes=%0d r9=%h required 1/0/0/0/%h",
                     dif.dbg_req_ready, stall_req, dif.dbg_rsp_valid, bad, rf_mem[9], old9);
        end
    endtask

    task automatic test_random();
        int ti, tr, th, nw, nr, sf, ns, pe, us, rr, ra;
        logic [4:0] wa; logic [31:0] wdat, rd, sn; logic er;
        for (int n = 0; n < 40; n++) begin
            logic we = 1'($urandom);
            logic [4:0] a = 5'($urandom);
            logic [31:0] v = $urandom;
            int busy = int'($urandom_range(0, 7));
            int hold = int'($urandom_range(1, 3));
            logic wr0 = we && (a == 5'd0);
            int e_iss = wr0 ? -1 : busy + 1;
            int e_rsp = wr0 ? 1 : busy + 2;
            int e_ns  = (!wr0 && busy >= LIM) ? busy - LIM + 1 : 0;
            run_cmd(we, a, v, busy, hold, ti, tr, th, nw, nr, sf, ns, pe, us, rr, ra, wa, wdat, rd, er, sn);
            if (we && a != 5'd0) ref_rf[a] = v;
            checks++;
            if (ti !== e_iss || tr !== e_rsp || th !== e_rsp + hold || ns !== e_ns) begin
                errors++;
                $display("FAIL rand_timing #%0d we=%b a=%0d busy=%0d got iss=%0d rsp=%0d hs=%0d stall=%0d required %0d/%0d/%0d/%0d",
                         n, we, a, busy, ti, tr, th, ns, e_iss, e_rsp, e_rsp + hold, e_ns);
            end
            checks++;
            if (rd !== (we ? 32'd0 : sn) || er !== wr0) begin
                errors++;
                $display("FAIL rand_rsp #%0d we=%b a=%0d got rdata=%h err=%b required %h/%b",
                         n, we, a, rd, er, we ? 32'd0 : sn, wr0);
            end
            checks++;
            if (nw !== int'(we && !wr0) || nr !== int'(!we) || (we && !wr0 && (wa !== a || wdat !== v)) ||
                pe !== 0 || us !== 0 || rr !== 0 || ra !== 1) begin
                errors++;
                $display("FAIL rand_port #%0d got wr=%0d rd=%0d wa=%0d wd=%h pt=%0d unst=%0d rdy=%0d acc=%0d required %0d/%0d/%0d/%h/0/0/0/1",
                         n, nw, nr, wa, wdat, pe, us, rr, ra, int'(we && !wr0), int'(!we), a, v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reg0();
        test_wb_busy();
        test_starve();
        test_rsp_hold();
        test_reset_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
